// File: rtl/video_gen_pkg.sv
// Shared definitions for video stream sources: pattern selects, FSM encoding and
// timing helpers.
package video_gen_pkg;

    localparam logic [1:0] PAT_RAMP  = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_CONST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vg_state_e;

    // Line or frame period: active span plus blanking, widened to counter width.
    function automatic logic [11:0] calc_total(input logic [10:0] active_len,
                                               input logic [10:0] blank_len);
        return {1'b0, active_len} + {1'b0, blank_len};
    endfunction

    function automatic logic checker_bit(input logic [11:0] x,
                                         input logic [11:0] y,
                                         input int unsigned shift);
        return |(((x ^ y) >> shift) & 12'd1);
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Free-running h/v raster counters with active, sync and frame-boundary decode.
// Counters are forced to 0 whenever run is low.
module video_timing_cnt
    import video_gen_pkg::*;
#(
    parameter logic [10:0] IMG_WIDTH  = 11'd640,
    parameter logic [10:0] IMG_HEIGHT = 11'd480,
    parameter logic [10:0] H_BLANK    = 11'd160,
    parameter logic [10:0] H_SYNC     = 11'd96,
    parameter logic [10:0] V_BLANK    = 11'd45,
    parameter logic [10:0] V_SYNC     = 11'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        frame_end,
    output logic        first_pixel,
    output logic        last_pixel
);

    localparam logic [11:0] H_TOTAL  = calc_total(IMG_WIDTH, H_BLANK);
    localparam logic [11:0] V_TOTAL  = calc_total(IMG_HEIGHT, V_BLANK);
    localparam logic [11:0] H_ACT    = {1'b0, IMG_WIDTH};
    localparam logic [11:0] HS_END   = calc_total(IMG_WIDTH, H_SYNC);
    localparam logic [11:0] V_ACT_LO = {1'b0, V_BLANK};
    localparam logic [11:0] VS_END   = {1'b0, V_SYNC};

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        h_wrap_s, v_wrap_s;

    // Next counter values: hold at origin when stopped, else advance and wrap.
    always_comb begin
        h_wrap_s = (h_cnt_q == (H_TOTAL - 12'd1));
        v_wrap_s = (v_cnt_q == (V_TOTAL - 12'd1));
        if (!run) begin
            h_cnt_d = 12'd0;
            v_cnt_d = 12'd0;
        end else if (h_wrap_s) begin
            h_cnt_d = 12'd0;
            v_cnt_d = v_wrap_s ? 12'd0 : (v_cnt_q + 12'd1);
        end else begin
            h_cnt_d = h_cnt_q + 12'd1;
            v_cnt_d = v_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Region and boundary decode of the current counter position.
    always_comb begin
        h_cnt       = h_cnt_q;
        v_cnt       = v_cnt_q;
        active      = (h_cnt_q < H_ACT) && (v_cnt_q >= V_ACT_LO);
        hsync       = (h_cnt_q >= H_ACT) && (h_cnt_q < HS_END);
        vsync       = (v_cnt_q < VS_END);
        frame_start = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        frame_end   = h_wrap_s && v_wrap_s;
        first_pixel = (h_cnt_q == 12'd0) && (v_cnt_q == V_ACT_LO);
        last_pixel  = (h_cnt_q == (H_ACT - 12'd1)) && v_wrap_s;
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Video test-pattern source: run/drain FSM, pattern datapath and registered stream outputs.
// Optional build macro VIDEO_PATTERN_GEN_STAMP_EN stamps a frame number on each frame's first pixel.
module video_pattern_gen
    import video_gen_pkg::*;
#(
    parameter logic [10:0] IMG_WIDTH   = 11'd640,
    parameter logic [10:0] IMG_HEIGHT  = 11'd480,
    parameter logic [10:0] H_BLANK     = 11'd160,
    parameter logic [10:0] H_SYNC      = 11'd96,
    parameter logic [10:0] V_BLANK     = 11'd45,
    parameter logic [10:0] V_SYNC      = 11'd2,
    parameter int unsigned CHECK_SHIFT = 3,
    parameter logic [7:0]  FILL_VALUE  = 8'h80
) (
    input  logic       video_clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       video_vs,
    output logic       video_hs,
    output logic       video_de,
    output logic [7:0] video_data,
    output logic       frame_done
);

    vg_state_e   state_q, state_d;
    logic [1:0]  pat_q, pat_d;
    logic [7:0]  ramp_q, ramp_d;
    logic        vs_q, vs_d, hs_q, hs_d, de_q, de_d, done_q, done_d;
    logic [7:0]  data_q, data_d;

    logic        run_s;
    logic [11:0] h_cnt_s, v_cnt_s, y_s;
    logic        active_s, hsync_s, vsync_s;
    logic        frame_start_s, frame_end_s, last_pixel_s;
    logic [7:0]  pix_s, out_pix_s;
`ifdef VIDEO_PATTERN_GEN_STAMP_EN
    logic        first_pixel_s;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
`endif

    assign run_s = (state_q != ST_IDLE);

    video_timing_cnt #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .H_BLANK    (H_BLANK),
        .H_SYNC     (H_SYNC),
        .V_BLANK    (V_BLANK),
        .V_SYNC     (V_SYNC)
    ) u_timing (
        .clk         (video_clk),
        .rst_n       (rst_n),
        .run         (run_s),
        .h_cnt       (h_cnt_s),
        .v_cnt       (v_cnt_s),
        .active      (active_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .frame_start (frame_start_s),
        .frame_end   (frame_end_s),
`ifdef VIDEO_PATTERN_GEN_STAMP_EN
        .first_pixel (first_pixel_s),
`else
        .first_pixel (),
`endif
        .last_pixel  (last_pixel_s)
    );

    // Run/drain control; stopping is only allowed on a frame boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
                else        state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (enable)           state_d = ST_RUN;
                else if (frame_end_s) state_d = ST_IDLE;
                else                  state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable)           state_d = ST_RUN;
                else if (frame_end_s) state_d = ST_IDLE;
                else                  state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pattern select latch, ramp counter and pixel value for the current position.
    always_comb begin
        y_s = v_cnt_s - {1'b0, V_BLANK};
        if (run_s && frame_start_s) pat_d = pattern_sel;
        else                        pat_d = pat_q;
        if (run_s && frame_start_s)  ramp_d = 8'd0;
        else if (run_s && active_s)  ramp_d = ramp_q + 8'd1;
        else                         ramp_d = ramp_q;
        case (pat_q)
            PAT_RAMP:  pix_s = ramp_q;
            PAT_GRAD:  pix_s = h_cnt_s[7:0];
            PAT_CHECK: pix_s = checker_bit(h_cnt_s, y_s, CHECK_SHIFT) ? 8'hFF : 8'h00;
            PAT_CONST: pix_s = FILL_VALUE;
            default:   pix_s = 8'h00;
        endcase
    end

`ifdef VIDEO_PATTERN_GEN_STAMP_EN
    // Frame number overrides the first pixel; the ramp still counts that pixel.
    always_comb begin
        if (run_s && last_pixel_s) frame_cnt_d = frame_cnt_q + 8'd1;
        else                       frame_cnt_d = frame_cnt_q;
        if (first_pixel_s) out_pix_s = frame_cnt_q;
        else               out_pix_s = pix_s;
    end

    // Frame number register.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= 8'd0;
        else        frame_cnt_q <= frame_cnt_d;
    end
`else
    // Pure pattern output.
    always_comb begin
        out_pix_s = pix_s;
    end
`endif

    // Output stage: everything is zero while idle and data is blanked outside the active area.
    always_comb begin
        vs_d   = run_s & vsync_s;
        hs_d   = run_s & hsync_s;
        de_d   = run_s & active_s;
        done_d = run_s & active_s & last_pixel_s;
        if (run_s && active_s) data_d = out_pix_s;
        else                   data_d = 8'h00;
    end

    // FSM, datapath and output registers.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= PAT_RAMP;
            ramp_q  <= 8'd0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            de_q    <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ramp_q  <= ramp_d;
            vs_q    <= vs_d;
            hs_q    <= hs_d;
            de_q    <= de_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign video_vs   = vs_q;
    assign video_hs   = hs_q;
    assign video_de   = de_q;
    assign video_data = data_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a 5x5 image, 11x8 = 88-cycle frame.
module tb_video_pattern_gen;

    logic       video_clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] pattern_sel;
    logic       video_vs, video_hs, video_de, frame_done;
    logic [7:0] video_data;

    logic [8:0] exp_q[$];
    logic [8:0] exp_e;
    int         checks = 0;
    int         errors = 0;
    int         fcount = 0;

    always #5 video_clk = ~video_clk;

    video_pattern_gen #(
        .IMG_WIDTH   (11'd5),
        .IMG_HEIGHT  (11'd5),
        .H_BLANK     (11'd6),
        .H_SYNC      (11'd2),
        .V_BLANK     (11'd3),
        .V_SYNC      (11'd1),
        .CHECK_SHIFT (0),
        .FILL_VALUE  (8'h80)
    ) dut (
        .video_clk   (video_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .video_vs    (video_vs),
        .video_hs    (video_hs),
        .video_de    (video_de),
        .video_data  (video_data),
        .frame_done  (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected pixels of one frame: {frame_done, data} per active cycle.
    task automatic push_frame(input int pat);
        logic [7:0] v;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                case (pat)
                    0:       v = 8'(y * 5 + x);
                    1:       v = 8'(x);
                    2:       v = (((x ^ y) & 1) != 0) ? 8'hFF : 8'h00;
                    default: v = 8'h80;
                endcase
`ifdef VIDEO_PATTERN_GEN_STAMP_EN
                if (x == 0 && y == 0) v = 8'(fcount);
`endif
                exp_q.push_back({(x == 4 && y == 4), v});
            end
        end
        fcount++;
    endtask

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    // Monitor: every active pixel is popped and compared; blank cycles must carry zeros.
    always @(negedge video_clk) begin
        if (rst_n === 1'b1) begin
            if (video_de === 1'b1) begin
                check("hs_de_overlap", {31'd0, video_hs}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got data 'h%0h, expected no pixel at %0t", video_data, $time);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("pixel", {23'd0, frame_done, video_data}, {23'd0, exp_e});
                end
            end else begin
                check("blank_zero", {23'd0, frame_done, video_data}, 32'd0);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) tick();
        check("rst_vs",   {31'd0, video_vs}, 32'd0);
        check("rst_hs",   {31'd0, video_hs}, 32'd0);
        check("rst_de",   {31'd0, video_de}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_data", {24'd0, video_data}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_vs", {31'd0, video_vs}, 32'd0);

        // Frames 0-2 ramp, 3 gradient, 4 checker; enable drops inside frame 4.
        push_frame(0);
        push_frame(0);
        push_frame(0);
        push_frame(1);
        push_frame(2);
        enable = 1'b1;
        tick();
        check("vs_after_k", {31'd0, video_vs}, 32'd0);
        tick();
        check("vs_after_k1", {31'd0, video_vs}, 32'd1);
        for (int j = 1; j <= 540; j++) begin
            tick();
            if (j == 5)   check("hs_start", {31'd0, video_hs}, 32'd1);
            if (j == 7)   check("hs_end",   {31'd0, video_hs}, 32'd0);
            if (j == 32)  check("de_before_first", {31'd0, video_de}, 32'd0);
            if (j == 33)  check("de_first", {31'd0, video_de}, 32'd1);
            if (j == 81)  check("frame_done_pos", {31'd0, frame_done}, 32'd1);
            if (j == 87)  check("vs_last_cycle", {31'd0, video_vs}, 32'd0);
            if (j == 88)  check("vs_period", {31'd0, video_vs}, 32'd1);
            if (j == 169) check("frame_done_f1", {31'd0, frame_done}, 32'd1);
            if (j == 352) check("vs_frame4", {31'd0, video_vs}, 32'd1);
            if (j == 216) pattern_sel = 2'd1;
            if (j == 300) pattern_sel = 2'd2;
            if (j == 382) enable = 1'b0;
            if (j >= 440)
                check("drain_quiet", {20'd0, video_vs, video_hs, video_de, frame_done, video_data}, 32'd0);
        end
        check("queue_empty_1", exp_q.size(), 32'd0);

        // Async reset mid-line, then three constant frames.
        pattern_sel = 2'd3;
        push_frame(3);
        enable = 1'b1;
        tick();
        tick();
        for (int j = 1; j <= 35; j++) tick();
        check("de_before_reset", {31'd0, video_de}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {20'd0, video_vs, video_hs, video_de, frame_done, video_data}, 32'd0);
        exp_q.delete();
        fcount = 0;
        tick();
        tick();
        check("held_rst_outputs", {20'd0, video_vs, video_hs, video_de, frame_done, video_data}, 32'd0);
        push_frame(3);
        push_frame(3);
        push_frame(3);
        rst_n = 1'b1;
        tick();
        check("vs_after_rel1", {31'd0, video_vs}, 32'd0);
        tick();
        check("vs_after_rel2", {31'd0, video_vs}, 32'd1);
        for (int j = 1; j <= 300; j++) begin
            tick();
            if (j == 200) enable = 1'b0;
            if (j >= 264)
                check("drain_quiet_2", {20'd0, video_vs, video_hs, video_de, frame_done, video_data}, 32'd0);
        end
        check("queue_empty_2", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Video stream source. Generates frame timing (`video_vs`, `video_hs`, `video_de`) and 8-bit pixel data for a configurable frame size. It drives the same video stream interface that `matrix_3x3` and the other window and filter stages consume. It replaces hand-written stimulus in benches and serves as the on-board test-pattern source ahead of the image pipeline.

## Interface
- `IMG_WIDTH`, 11'd640: active pixels per line.
- `IMG_HEIGHT`, 11'd480: active lines per frame.
- `H_BLANK`, 11'd160: blank cycles per line. Must be ≥ `H_SYNC` + 1.
- `H_SYNC`, 11'd96: `video_hs` width in cycles.
- `V_BLANK`, 11'd45: blank lines per frame. Must be ≥ `V_SYNC` + 1.
- `V_SYNC`, 11'd2: `video_vs` width in lines.
- `CHECK_SHIFT`, 3: checker square size is 2^`CHECK_SHIFT` pixels.
- `FILL_VALUE`, 8'h80: constant-pattern value.

Ports (one clock; reset is asynchronous and active-low):
- `video_clk`, in, 1: pixel clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: run request.
- `pattern_sel`, in, 2: 0 = frame ramp, 1 = horizontal gradient, 2 = checker, 3 = constant.
- `video_vs`, out, 1: vertical sync, active high.
- `video_hs`, out, 1: horizontal sync, active high.
- `video_de`, out, 1: active-pixel strobe.
- `video_data`, out, 8: pixel value. Forced to 0 when `video_de` = 0.
- `frame_done`, out, 1: one-cycle pulse on the last active pixel of a frame.

## Operation
- `H_TOTAL` = `IMG_WIDTH` + `H_BLANK`; `V_TOTAL` = `IMG_HEIGHT` + `V_BLANK`.
- Counter `h_cnt` runs 0..`H_TOTAL`-1 and wraps; `v_cnt` increments on each `h_cnt` wrap and wraps at `V_TOTAL`-1. Both counters are 12 bits wide.
- Active region: `h_cnt` < `IMG_WIDTH` and `v_cnt` ≥ `V_BLANK`.
- `video_hs` = 1 while `IMG_WIDTH` ≤ `h_cnt` < `IMG_WIDTH` + `H_SYNC`.
- `video_vs` = 1 while `v_cnt` < `V_SYNC`.
- Pixel coordinates: x = `h_cnt`, y = `v_cnt` − `V_BLANK`.
- Patterns:
  - Ramp: 8-bit counter cleared at frame start, incremented after every active pixel, wraps 255→0.
  - Gradient: x[7:0].
  - Checker: 8'hFF if (x ^ y)[`CHECK_SHIFT`] = 1, else 0.
  - Constant: `FILL_VALUE`.
- `pattern_sel` is latched only at frame start (`h_cnt` = 0, `v_cnt` = 0). A change mid-frame takes effect at the next frame.
- FSM states:
  - IDLE: counters held at 0, all outputs 0. Moves to RUN when `enable` = 1.
  - RUN: counters free-run. Moves to DRAIN when `enable` = 0.
  - DRAIN: completes the current frame. Moves to IDLE on the last cycle of the frame (`h_cnt` = `H_TOTAL`-1, `v_cnt` = `V_TOTAL`-1). If `enable` reasserts during DRAIN, returns to RUN with no gap.
- Only whole frames are emitted; there are never truncated frames.
- Reset mid-frame: all state returns to IDLE immediately and asynchronously; all outputs drop to 0.

## Timing
- Reset values: `video_vs`, `video_hs`, `video_de`, `frame_done` = 0; `video_data` = 8'h00; FSM = IDLE.
- All outputs are registered, one cycle behind counter state.
- If the IDLE→RUN edge is k, counters hold 0 after edge k and `video_vs` = 1 after edge k+1.
- The first `video_de` follows the first `video_vs` assertion by `V_BLANK`·`H_TOTAL` cycles.
- `frame_done` is coincident with the final `video_de` cycle of the frame.
- Within a line, `video_de` stays high for exactly `IMG_WIDTH` consecutive cycles. `video_hs` never overlaps `video_de`.

## Configuration
- `VIDEO_PATTERN_GEN_STAMP_EN` defined: adds an 8-bit frame counter (0 after reset, +1 per `frame_done`, wraps). The first active pixel of each frame carries that counter value instead of the pattern value; in ramp mode, ramp numbering is unaffected.
- Undefined: no counter is present and every pixel is pure pattern.

## Structure
- Package `video_gen_pkg`:
  - pattern-select constants `PAT_RAMP`, `PAT_GRAD`, `PAT_CHECK`, `PAT_CONST`;
  - FSM state encoding;
  - `H_TOTAL`/`V_TOTAL` helper function.
- Sub-module `video_timing_cnt`: h/v counters, active/sync decode, frame-start and frame-end flags. Reusable by other sources.
- The top level holds the FSM, pattern datapath and output registers.

## Test plan
All scenarios use `IMG_WIDTH` = 5, `IMG_HEIGHT` = 5, `H_BLANK` = 6, `H_SYNC` = 2, `V_BLANK` = 3, `V_SYNC` = 1, giving 11 × 8 = 88 cycles per frame.
- Ramp, `enable` held high: `video_data` = 0..24 across 25 `video_de` cycles, in 5 bursts of 5 with 6-cycle gaps. `frame_done` fires with data = 24. The next frame restarts at 0 with an 88-cycle period.
- `enable` dropped at cycle 30 of a frame: the frame completes through cycle 87. All outputs are 0 afterwards. No further `video_vs`.
- `pattern_sel` 0→1 mid-frame: the current frame stays ramp. The next frame shows the gradient 0,1,2,3,4 on every line.
- Checker with `CHECK_SHIFT` = 0: line y = 0 reads 00,FF,00,FF,00; line y = 1 reads FF,00,FF,00,FF.
- `rst_n` pulsed low mid-line: outputs go to 0 at once, without waiting for a clock. After release, with `enable` high, `video_vs` rises 2 edges later.
- With `VIDEO_PATTERN_GEN_STAMP_EN` defined, constant pattern: first pixel of frames 0, 1, 2 = 00, 01, 02. All other pixels = 80.
